load_store_unit: RTL and testbench

- Data-side initiator for MemoryController; sits between the execute stage and the controller's data port.
- Turns byte, halfword and word load/store requests into word-wide accesses on the addrD/writeData/writeEnable/dataD interface.
- Sub-word stores are done as read-modify-write. Results come back as single-cycle response pulses.
- Handles alignment checking, lane extraction and sign/zero extension.

---
 rtl/load_store_unit.sv | 112 +++++++++++
 tb/tb_load_store_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store initiator with read-modify-write for sub-word stores
module load_store_unit #(
    parameter int READ_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] addrD,
    output logic [31:0] writeData,
    output logic        writeEnable,
    input  logic [31:0] dataD
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [3:0] RW = 4'(READ_WAIT);

    state_t      state, state_n;
    logic [3:0]  cnt;
    logic [31:0] addr, wdata, rbuf;
    logic [1:0]  size;
    logic        sgn, wr, err;
    logic        mis, rd_done;
    logic [31:0] cur_addr, mask, merged, ext;
    logic [4:0]  sh;
    logic [15:0] lane;

    // Alignment of the incoming request; only meaningful in IDLE
    assign mis = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign rd_done  = (state == READ) && (cnt == RW);
    assign cur_addr = (state == IDLE) ? req_addr : addr;
    assign sh       = {addr[1:0], 3'b000};
    assign mask     = (size == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    // The merge happens on the READ exit edge, so it uses live memory data, not the buffer
    assign merged   = (dataD & ~mask) | ((wdata << sh) & mask);
    assign lane     = 16'(rbuf >> sh);
    assign ext      = (size == 2'b10) ? rbuf :
                      (size == 2'b00) ? {{24{sgn & lane[7]}}, lane[7:0]} :
                                        {{16{sgn & lane[15]}}, lane};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid) state_n = mis ? RESP : (req_write && req_size == 2'b10) ? WRITE : READ;
            READ:    if (rd_done) state_n = wr ? WRITE : RESP;
            WRITE:   state_n = RESP;
            default: state_n = IDLE;
        endcase
    end

    // Response and handshake outputs decoded from the current state
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_err   = resp_valid && err;
        resp_rdata = (resp_valid && !err && !wr) ? ext : 32'h0;
    end

    // Request latch, read wait counter and read buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr  <= 32'h0;
            wdata <= 32'h0;
            size  <= 2'b00;
            sgn   <= 1'b0;
            wr    <= 1'b0;
            err   <= 1'b0;
            rbuf  <= 32'h0;
            cnt   <= 4'd0;
        end else begin
            if (state == IDLE && req_valid) begin
                addr  <= req_addr;
                wdata <= req_wdata;
                size  <= req_size;
                sgn   <= req_signed;
                wr    <= req_write;
                err   <= mis;
            end
            if (rd_done) rbuf <= dataD;
            cnt <= (state == READ) ? cnt + 4'd1 : 4'd0;
        end
    end

    // Registered memory port, driven from the state being entered so it lines up with READ/WRITE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrD       <= 32'h0;
            writeData   <= 32'h0;
            writeEnable <= 1'b0;
        end else begin
            addrD       <= (state_n == READ || state_n == WRITE) ? {cur_addr[31:2], 2'b00} : 32'h0;
            writeEnable <= (state_n == WRITE);
            writeData   <= (state_n == WRITE) ? ((state == IDLE) ? req_wdata : merged) : 32'h0;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the load/store unit against a small word memory
module tb_load_store_unit;
    logic        clk, rst_n;
    logic        rv0, rv3;
    logic        req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        ready0, resp_valid0, err0, we0;
    logic [31:0] rdata0, addrD0, wd0, dataD0;
    logic        ready3, resp_valid3, err3, we3;
    logic [31:0] rdata3, addrD3, wd3, dataD3;
    logic [31:0] mem [256];
    int vectors = 0;
    int miscompares = 0;

    load_store_unit #(.READ_WAIT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(ready0), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid0), .resp_rdata(rdata0), .resp_err(err0), .addrD(addrD0),
        .writeData(wd0), .writeEnable(we0), .dataD(dataD0)
    );

    load_store_unit #(.READ_WAIT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_ready(ready3), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid3), .resp_rdata(rdata3), .resp_err(err3), .addrD(addrD3),
        .writeData(wd3), .writeEnable(we3), .dataD(dataD3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (we0) mem[addrD0[9:2]] <= wd0;
    assign dataD0 = mem[addrD0[9:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_wes,
                       input logic [31:0] exp_wa, input logic [31:0] exp_wd);
        int lat, wes;
        logic [31:0] wa, wdv, aor;
        chk({tag, "_ready"}, 32'(ready0), 32'd1);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d; rv0 = 1'b1;
        @(posedge clk); #1;
        rv0 = 1'b0;
        lat = 1; wes = 0; wa = 0; wdv = 0; aor = 0;
        while (!resp_valid0 && lat < 40) begin
            if (we0) begin wes++; wa = addrD0; wdv = wd0; end
            aor |= addrD0;
            @(posedge clk); #1;
            lat++;
        end
        if (we0) wes++;
        aor |= addrD0;
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, rdata0, exp_rd);
        chk({tag, "_err"}, 32'(err0), 32'(exp_err));
        chk({tag, "_we_cycles"}, 32'(wes), 32'(exp_wes));
        if (exp_wes > 0) begin
            chk({tag, "_we_addr"}, wa, exp_wa);
            chk({tag, "_we_data"}, wdv, exp_wd);
        end
        if (exp_err) chk({tag, "_addr_idle"}, aor, 32'h0);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(resp_valid0), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; rv0 = 1'b0; rv3 = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; dataD3 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready0), 32'd1);
        chk("rst_valid", 32'(resp_valid0), 32'd0);
        chk("rst_rdata", rdata0, 32'h0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_addrD", addrD0, 32'h0);
        chk("rst_wdata", wd0, 32'h0);
        chk("rst_we", 32'(we0), 32'd0);
        chk("rst_ready3", 32'(ready3), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run("st_word", 1, 2'b10, 0, 32'h1000_0010, 32'hDEAD_BEEF, 2, 32'h0, 0, 1, 32'h1000_0010, 32'hDEAD_BEEF);
        run("ld_word", 0, 2'b10, 0, 32'h1000_0010, 32'h0, 2, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0);
        run("st_fill", 1, 2'b10, 0, 32'h1000_0020, 32'h4242_4242, 2, 32'h0, 0, 1, 32'h1000_0020, 32'h4242_4242);
        run("st_byte", 1, 2'b00, 0, 32'h1000_0022, 32'h1234_56AB, 3, 32'h0, 0, 1, 32'h1000_0020, 32'h42AB_4242);
        run("ld_rmw", 0, 2'b10, 0, 32'h1000_0020, 32'h0, 2, 32'h42AB_4242, 0, 0, 32'h0, 32'h0);
        run("st_half", 1, 2'b01, 0, 32'h1000_0022, 32'h9999_CAFE, 3, 32'h0, 0, 1, 32'h1000_0020, 32'hCAFE_4242);
        run("st_sx", 1, 2'b10, 0, 32'hDFFF_FF10, 32'h80F0_7F01, 2, 32'h0, 0, 1, 32'hDFFF_FF10, 32'h80F0_7F01);
        run("ld_sh12", 0, 2'b01, 1, 32'hDFFF_FF12, 32'h0, 2, 32'hFFFF_80F0, 0, 0, 32'h0, 32'h0);
        run("ld_ub13", 0, 2'b00, 0, 32'hDFFF_FF13, 32'h0, 2, 32'h0000_0080, 0, 0, 32'h0, 32'h0);
        run("ld_sb11", 0, 2'b00, 1, 32'hDFFF_FF11, 32'h0, 2, 32'h0000_007F, 0, 0, 32'h0, 32'h0);
        run("ld_sb13", 0, 2'b00, 1, 32'hDFFF_FF13, 32'h0, 2, 32'hFFFF_FF80, 0, 0, 32'h0, 32'h0);
        run("ld_uh10", 0, 2'b01, 0, 32'hDFFF_FF10, 32'h0, 2, 32'h0000_7F01, 0, 0, 32'h0, 32'h0);
        run("ld_sh10", 0, 2'b01, 1, 32'hDFFF_FF10, 32'h0, 2, 32'h0000_7F01, 0, 0, 32'h0, 32'h0);
        run("mis_word", 0, 2'b10, 0, 32'h1000_0011, 32'h0, 1, 32'h0, 1, 0, 32'h0, 32'h0);
        run("mis_half", 1, 2'b01, 0, 32'h1000_0013, 32'h1234, 1, 32'h0, 1, 0, 32'h0, 32'h0);
        run("mis_rsvd", 0, 2'b11, 0, 32'h0000_0000, 32'h0, 1, 32'h0, 1, 0, 32'h0, 32'h0);
        run("ld_after", 0, 2'b10, 0, 32'h1000_0020, 32'h0, 2, 32'hCAFE_4242, 0, 0, 32'h0, 32'h0);

        req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h0000_0040; rv3 = 1'b1;
        @(posedge clk); #1;
        rv3 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            dataD3 = 32'h100 + 32'(k);
            chk("rw3_ready", 32'(ready3), 32'd0);
            chk("rw3_valid", 32'(resp_valid3), 32'd0);
            chk("rw3_addr", addrD3, 32'h0000_0040);
            @(posedge clk); #1;
        end
        dataD3 = 32'hFFFF_FFFF;
        chk("rw3_resp", 32'(resp_valid3), 32'd1);
        chk("rw3_rdata", rdata3, 32'h0000_0104);
        chk("rw3_ready_resp", 32'(ready3), 32'd0);
        @(posedge clk); #1;
        chk("rw3_idle", 32'(ready3), 32'd1);

        req_write = 1'b1; req_size = 2'b10; req_addr = 32'h1000_0030; req_wdata = 32'h1111_1111; rv0 = 1'b1;
        @(posedge clk); #1;
        rv0 = 1'b0;
        chk("rstw_we_on", 32'(we0), 32'd1);
        chk("rstw_addr_on", addrD0, 32'h1000_0030);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_we_drop", 32'(we0), 32'd0);
        chk("rstw_addr_drop", addrD0, 32'h0);
        chk("rstw_wd_drop", wd0, 32'h0);
        @(posedge clk); #1;
        chk("rstw_no_resp", 32'(resp_valid0), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstw_no_resp2", 32'(resp_valid0), 32'd0);
        chk("rstw_ready", 32'(ready0), 32'd1);
        run("ld_post_rst", 0, 2'b10, 0, 32'h1000_0010, 32'h0, 2, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
